// File: rtl/video_timing_pkg.sv
// Shared constants for the run-time video mode sequencer: mode table, widths, FSM encoding.
package video_timing_pkg;

  localparam int unsigned CW         = 12;
  localparam int unsigned MODE_IDX_W = 2;
  localparam int unsigned MAX_MODES  = 1 << MODE_IDX_W;
  localparam int unsigned NUM_FIELDS = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_LOAD       = 2'd2;
  localparam logic [1:0] ST_SETTLE     = 2'd3;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned addr;
    int unsigned front;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } mode_timing_t;

  // Horizontal in pixels, vertical in lines.
  localparam mode_timing_t MODE_TABLE [MAX_MODES] = '{
    '{h: '{144, 248, 1280, 16}, v: '{3, 38, 1024, 1}},  // 1280x1024@75
    '{h: '{96,  48,  640,  16}, v: '{2, 33, 480,  10}}, // 640x480@60
    '{h: '{128, 88,  800,  40}, v: '{4, 23, 600,  1}},  // 800x600@60
    '{h: '{136, 160, 1024, 24}, v: '{6, 29, 768,  3}}   // 1024x768@60
  };

  function automatic int unsigned axis_max(axis_timing_t a);
    int unsigned m;
    m = a.sync;
    if (a.back > m) m = a.back;
    if (a.addr > m) m = a.addr;
    if (a.front > m) m = a.front;
    return m;
  endfunction

  function automatic int unsigned table_max();
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < MAX_MODES; i++) begin
      if (axis_max(MODE_TABLE[i].h) > m) m = axis_max(MODE_TABLE[i].h);
      if (axis_max(MODE_TABLE[i].v) > m) m = axis_max(MODE_TABLE[i].v);
    end
    return m;
  endfunction

endpackage

// File: rtl/video_mode_rom.sv
// Combinational mode table: mode index in, the eight H/V timing fields out.
module video_mode_rom #(
  parameter int unsigned CW = video_timing_pkg::CW
) (
  input  logic [video_timing_pkg::MODE_IDX_W-1:0] idx_i,
  output logic [CW-1:0]                           h_sync_o,
  output logic [CW-1:0]                           h_back_o,
  output logic [CW-1:0]                           h_addr_o,
  output logic [CW-1:0]                           h_front_o,
  output logic [CW-1:0]                           v_sync_o,
  output logic [CW-1:0]                           v_back_o,
  output logic [CW-1:0]                           v_addr_o,
  output logic [CW-1:0]                           v_front_o
);
  import video_timing_pkg::*;

  mode_timing_t entry;

  always_comb begin
    entry     = MODE_TABLE[idx_i];
    h_sync_o  = CW'(entry.h.sync);
    h_back_o  = CW'(entry.h.back);
    h_addr_o  = CW'(entry.h.addr);
    h_front_o = CW'(entry.h.front);
    v_sync_o  = CW'(entry.v.sync);
    v_back_o  = CW'(entry.v.back);
    v_addr_o  = CW'(entry.v.addr);
    v_front_o = CW'(entry.v.front);
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Run-time video mode sequencer: switches modes at frame boundaries, blanks video while the
// timing generator reloads and its sync settles, then re-enables video.
module video_mode_ctrl #(
  parameter int unsigned NUM_MODES     = 4,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned CW            = video_timing_pkg::CW
) (
  input  logic                                    pixel_clock,
  input  logic                                    reset,
  input  logic                                    mode_req,
  input  logic [video_timing_pkg::MODE_IDX_W-1:0] mode_sel,
  input  logic                                    frame_start,
  output logic                                    mode_ack,
  output logic                                    mode_nak,
  output logic                                    mode_drop,
  output logic                                    busy,
  output logic [video_timing_pkg::MODE_IDX_W-1:0] cur_mode,
  output logic                                    cfg_load,
  output logic                                    video_enable,
  output logic [CW-1:0]                           h_sync,
  output logic [CW-1:0]                           h_back,
  output logic [CW-1:0]                           h_addr,
  output logic [CW-1:0]                           h_front,
  output logic [CW-1:0]                           v_sync,
  output logic [CW-1:0]                           v_back,
  output logic [CW-1:0]                           v_addr,
  output logic [CW-1:0]                           v_front
);
  import video_timing_pkg::*;

  if (NUM_MODES < 1 || NUM_MODES > MAX_MODES) begin : g_bad_num_modes
    $error("video_mode_ctrl: NUM_MODES must be 1..%0d", MAX_MODES);
  end
  if (SETTLE_FRAMES > 15) begin : g_bad_settle
    $error("video_mode_ctrl: SETTLE_FRAMES must be 0..15");
  end
  if (64'(table_max()) >= (64'd1 << CW)) begin : g_bad_cw
    $error("video_mode_ctrl: mode table value does not fit in CW bits");
  end

  typedef logic [NUM_FIELDS-1:0][CW-1:0] fields_t;

  // Index 0 is h_sync, index 7 is v_front.
  function automatic fields_t pack_fields(mode_timing_t t);
    return {CW'(t.v.front), CW'(t.v.addr), CW'(t.v.back), CW'(t.v.sync),
            CW'(t.h.front), CW'(t.h.addr), CW'(t.h.back), CW'(t.h.sync)};
  endfunction

  localparam fields_t    RstFields    = pack_fields(MODE_TABLE[0]);
  localparam logic [3:0] SettleTarget = 4'(SETTLE_FRAMES);

  logic [1:0]            state_q, state_d;
  logic [3:0]            settle_cnt_q, settle_cnt_d;
  logic [MODE_IDX_W-1:0] cur_mode_q, cur_mode_d;
  logic [MODE_IDX_W-1:0] sel_q, sel_d;
  logic                  boot_q, boot_d;
  logic                  busy_q, busy_d;
  logic                  video_enable_q, video_enable_d;
  logic                  ack_q, ack_d;
  logic                  nak_q, nak_d;
  logic                  drop_q, drop_d;
  logic                  load_q, load_d;
  fields_t               fields_q, fields_d;
  fields_t               rom_fields;

  logic [CW-1:0] rom_h_sync, rom_h_back, rom_h_addr, rom_h_front;
  logic [CW-1:0] rom_v_sync, rom_v_back, rom_v_addr, rom_v_front;

  video_mode_rom #(
    .CW (CW)
  ) u_rom (
    .idx_i     (sel_q),
    .h_sync_o  (rom_h_sync),
    .h_back_o  (rom_h_back),
    .h_addr_o  (rom_h_addr),
    .h_front_o (rom_h_front),
    .v_sync_o  (rom_v_sync),
    .v_back_o  (rom_v_back),
    .v_addr_o  (rom_v_addr),
    .v_front_o (rom_v_front)
  );

  assign rom_fields = {rom_v_front, rom_v_addr, rom_v_back, rom_v_sync,
                       rom_h_front, rom_h_addr, rom_h_back, rom_h_sync};

  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    cur_mode_d     = cur_mode_q;
    sel_d          = sel_q;
    boot_d         = boot_q;
    busy_d         = busy_q;
    video_enable_d = video_enable_q;
    fields_d       = fields_q;
    ack_d          = 1'b0;
    nak_d          = 1'b0;
    drop_d         = 1'b0;
    load_d         = 1'b0;

    if (mode_req && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (mode_req) begin
          if (32'(mode_sel) >= NUM_MODES) begin
            nak_d = 1'b1;
          end else if (mode_sel == cur_mode_q) begin
            ack_d = 1'b1;
          end else begin
            sel_d          = mode_sel;
            busy_d         = 1'b1;
            video_enable_d = 1'b0;
            state_d        = ST_WAIT_FRAME;
          end
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fields_d     = rom_fields;
        cur_mode_d   = sel_q;
        load_d       = 1'b1;
        settle_cnt_d = 4'd0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SettleTarget) begin
          // The settle that follows reset completes silently: nobody asked for it.
          ack_d          = ~boot_q;
          boot_d         = 1'b0;
          busy_d         = 1'b0;
          video_enable_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (frame_start) begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SETTLE;
      settle_cnt_q   <= 4'd0;
      cur_mode_q     <= '0;
      sel_q          <= '0;
      boot_q         <= 1'b1;
      busy_q         <= 1'b1;
      video_enable_q <= 1'b0;
      ack_q          <= 1'b0;
      nak_q          <= 1'b0;
      drop_q         <= 1'b0;
      load_q         <= 1'b0;
      fields_q       <= RstFields;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      cur_mode_q     <= cur_mode_d;
      sel_q          <= sel_d;
      boot_q         <= boot_d;
      busy_q         <= busy_d;
      video_enable_q <= video_enable_d;
      ack_q          <= ack_d;
      nak_q          <= nak_d;
      drop_q         <= drop_d;
      load_q         <= load_d;
      fields_q       <= fields_d;
    end
  end

  assign mode_ack     = ack_q;
  assign mode_nak     = nak_q;
  assign mode_drop    = drop_q;
  assign busy         = busy_q;
  assign cur_mode     = cur_mode_q;
  assign cfg_load     = load_q;
  assign video_enable = video_enable_q;
  assign h_sync       = fields_q[0];
  assign h_back       = fields_q[1];
  assign h_addr       = fields_q[2];
  assign h_front      = fields_q[3];
  assign v_sync       = fields_q[4];
  assign v_back       = fields_q[5];
  assign v_addr       = fields_q[6];
  assign v_front      = fields_q[7];

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: a 3-mode/2-frame-settle instance driven from a vector table,
// plus a 4-mode/zero-settle instance exercised by a hand-written sequence.
module tb_video_mode_ctrl;

  logic pixel_clock = 1'b0;
  logic reset;

  // Instance A: NUM_MODES=3, SETTLE_FRAMES=2
  logic        a_req, a_fs;
  logic [1:0]  a_sel;
  logic        a_ack, a_nak, a_drop, a_busy, a_load, a_ven;
  logic [1:0]  a_mode;
  logic [11:0] a_hs, a_hb, a_ha, a_hf, a_vs, a_vb, a_va, a_vf;

  // Instance B: NUM_MODES=4, SETTLE_FRAMES=0
  logic        b_req, b_fs;
  logic [1:0]  b_sel;
  logic        b_ack, b_nak, b_drop, b_busy, b_load, b_ven;
  logic [1:0]  b_mode;
  logic [11:0] b_hs, b_hb, b_ha, b_hf, b_vs, b_vb, b_va, b_vf;

  video_mode_ctrl #(.NUM_MODES(3), .SETTLE_FRAMES(2), .CW(12)) u_dut_a (
    .pixel_clock (pixel_clock), .reset (reset),
    .mode_req (a_req), .mode_sel (a_sel), .frame_start (a_fs),
    .mode_ack (a_ack), .mode_nak (a_nak), .mode_drop (a_drop), .busy (a_busy),
    .cur_mode (a_mode), .cfg_load (a_load), .video_enable (a_ven),
    .h_sync (a_hs), .h_back (a_hb), .h_addr (a_ha), .h_front (a_hf),
    .v_sync (a_vs), .v_back (a_vb), .v_addr (a_va), .v_front (a_vf)
  );

  video_mode_ctrl #(.NUM_MODES(4), .SETTLE_FRAMES(0), .CW(12)) u_dut_b (
    .pixel_clock (pixel_clock), .reset (reset),
    .mode_req (b_req), .mode_sel (b_sel), .frame_start (b_fs),
    .mode_ack (b_ack), .mode_nak (b_nak), .mode_drop (b_drop), .busy (b_busy),
    .cur_mode (b_mode), .cfg_load (b_load), .video_enable (b_ven),
    .h_sync (b_hs), .h_back (b_hb), .h_addr (b_ha), .h_front (b_hf),
    .v_sync (b_vs), .v_back (b_vb), .v_addr (b_va), .v_front (b_vf)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    logic       req;
    logic [1:0] sel;
    logic       fs;
    logic       busy;
    logic       ven;
    logic       ack;
    logic       nak;
    logic       drop;
    logic       load;
    logic [1:0] mode;
    int         fmode;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {h_sync, h_back, h_addr, h_front, v_sync, v_back, v_addr, v_front}
  function automatic logic [95:0] exp_fields(int m);
    case (m)
      0:       return {12'd144, 12'd248, 12'd1280, 12'd16, 12'd3, 12'd38, 12'd1024, 12'd1};
      1:       return {12'd96,  12'd48,  12'd640,  12'd16, 12'd2, 12'd33, 12'd480,  12'd10};
      2:       return {12'd128, 12'd88,  12'd800,  12'd40, 12'd4, 12'd23, 12'd600,  12'd1};
      default: return {12'd136, 12'd160, 12'd1024, 12'd24, 12'd6, 12'd29, 12'd768,  12'd3};
    endcase
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(logic req, logic [1:0] sel, logic fs, logic busy, logic ven, logic ack,
                     logic nak, logic drop, logic load, logic [1:0] mode, int fmode);
    vec_t v;
    v.req = req; v.sel = sel; v.fs = fs; v.busy = busy; v.ven = ven; v.ack = ack;
    v.nak = nak; v.drop = drop; v.load = load; v.mode = mode; v.fmode = fmode;
    vecs.push_back(v);
  endtask

  // Drive one vector, then compare A's registered outputs after the next edge.
  task automatic step(int idx);
    vec_t v;
    vec_t e;
    v = vecs[idx];
    a_req = v.req; a_sel = v.sel; a_fs = v.fs;
    exp_q.push_back(v);
    @(posedge pixel_clock);
    #1;
    a_req = 1'b0; a_fs = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("v%0d busy", idx), 128'(a_busy), 128'(e.busy));
    check($sformatf("v%0d video_enable", idx), 128'(a_ven), 128'(e.ven));
    check($sformatf("v%0d mode_ack", idx), 128'(a_ack), 128'(e.ack));
    check($sformatf("v%0d mode_nak", idx), 128'(a_nak), 128'(e.nak));
    check($sformatf("v%0d mode_drop", idx), 128'(a_drop), 128'(e.drop));
    check($sformatf("v%0d cfg_load", idx), 128'(a_load), 128'(e.load));
    check($sformatf("v%0d cur_mode", idx), 128'(a_mode), 128'(e.mode));
    check($sformatf("v%0d fields", idx),
          128'({a_hs, a_hb, a_ha, a_hf, a_vs, a_vb, a_va, a_vf}), 128'(exp_fields(e.fmode)));
  endtask

  task automatic run_range(int lo, int hi);
    for (int i = lo; i <= hi; i++) step(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_load;

    // Boot after reset: two frames of settle, enable without ack (vectors 0..5).
    //   req sel fs  busy ven ack nak drop load mode fmode
    add(0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    // Switch to mode 1 with drops during WAIT_FRAME and SETTLE (vectors 6..16).
    add(1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0,  1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0,  1, 0, 0, 0, 1, 0, 1, 1);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0,  0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1);
    // Same-mode ack, out-of-range nak, stray frame_start in IDLE (vectors 17..19).
    add(1, 1, 0,  0, 1, 1, 0, 0, 0, 1, 1);
    add(1, 3, 0,  0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1,  0, 1, 0, 0, 0, 0, 1, 1);
    // Switch to mode 2, stop part-way into SETTLE (vectors 20..23).
    add(1, 2, 0,  1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0,  1, 0, 0, 0, 0, 1, 2, 2);
    add(0, 0, 1,  1, 0, 0, 0, 0, 0, 2, 2);

    a_req = 1'b0; a_sel = 2'd0; a_fs = 1'b0;
    b_req = 1'b0; b_sel = 2'd0; b_fs = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge pixel_clock);
    #1;
    check("reset busy", 128'(a_busy), 128'(1));
    check("reset video_enable", 128'(a_ven), 128'(0));
    check("reset cur_mode", 128'(a_mode), 128'(0));
    check("reset pulses", 128'({a_ack, a_nak, a_drop, a_load}), 128'(0));
    check("reset fields", 128'({a_hs, a_hb, a_ha, a_hf, a_vs, a_vb, a_va, a_vf}),
          128'(exp_fields(0)));
    check("reset b busy", 128'(b_busy), 128'(1));
    reset = 1'b0;

    run_range(0, 23);

    // Asynchronous reset in the middle of the mode-2 settle.
    #2;
    reset = 1'b1;
    #1;
    check("async reset fields", 128'({a_hs, a_hb, a_ha, a_hf, a_vs, a_vb, a_va, a_vf}),
          128'(exp_fields(0)));
    check("async reset cur_mode", 128'(a_mode), 128'(0));
    check("async reset busy/ven", 128'({a_busy, a_ven}), 128'(2'b10));
    check("async reset pulses", 128'({a_ack, a_nak, a_drop, a_load}), 128'(0));
    @(posedge pixel_clock);
    #1;
    reset = 1'b0;
    run_range(0, 5);

    // Instance B: zero-frame settle, ack on the cycle after cfg_load.
    check("b idle after boot", 128'({b_busy, b_ven, b_ack, b_mode}), 128'(5'b01000));
    b_req = 1'b1; b_sel = 2'd3;
    @(posedge pixel_clock);
    #1;
    b_req = 1'b0;
    check("b busy/blank after req", 128'({b_busy, b_ven}), 128'(2'b10));
    b_fs = 1'b1;
    @(posedge pixel_clock);
    #1;
    b_fs = 1'b0;
    got_load = 1'b0;
    for (int c = 0; c < 8 && !got_load; c++) begin
      @(posedge pixel_clock);
      #1;
      if (b_load) got_load = 1'b1;
    end
    check("b cfg_load seen", 128'(got_load), 128'(1));
    check("b fields mode3", 128'({b_hs, b_hb, b_ha, b_hf, b_vs, b_vb, b_va, b_vf}),
          128'(exp_fields(3)));
    check("b cur_mode", 128'(b_mode), 128'(3));
    @(posedge pixel_clock);
    #1;
    check("b ack after load", 128'({b_ack, b_ven, b_busy, b_load}), 128'(4'b1100));
    check("b no nak/drop", 128'({b_nak, b_drop}), 128'(0));
    @(posedge pixel_clock);
    #1;
    check("b ack one cycle", 128'(b_ack), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
